// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings, status helpers and pipeline bubble values.
package y86_pkg;

    localparam logic [3:0] I_HALT   = 4'h0;
    localparam logic [3:0] I_NOP    = 4'h1;
    localparam logic [3:0] I_CMOVXX = 4'h2;
    localparam logic [3:0] I_IRMOVQ = 4'h3;
    localparam logic [3:0] I_RMMOVQ = 4'h4;
    localparam logic [3:0] I_MRMOVQ = 4'h5;
    localparam logic [3:0] I_OPQ    = 4'h6;
    localparam logic [3:0] I_JXX    = 4'h7;
    localparam logic [3:0] I_CALL   = 4'h8;
    localparam logic [3:0] I_RET    = 4'h9;
    localparam logic [3:0] I_PUSHQ  = 4'hA;
    localparam logic [3:0] I_POPQ   = 4'hB;

    localparam logic [3:0] F_ADD = 4'h0;
    localparam logic [3:0] F_SUB = 4'h1;
    localparam logic [3:0] F_AND = 4'h2;
    localparam logic [3:0] F_XOR = 4'h3;
    localparam logic [3:0] F_MUL = 4'h4;

    localparam logic [3:0] C_ALWAYS = 4'h0;
    localparam logic [3:0] C_LE     = 4'h1;
    localparam logic [3:0] C_L      = 4'h2;
    localparam logic [3:0] C_E      = 4'h3;
    localparam logic [3:0] C_NE     = 4'h4;
    localparam logic [3:0] C_GE     = 4'h5;
    localparam logic [3:0] C_G      = 4'h6;

    localparam logic [3:0] RNONE = 4'hF;

    // Bit positions inside the 3-bit {hlt, in_inst, in_mem} status word.
    localparam int STAT_HLT = 2;
    localparam int STAT_INS = 1;
    localparam int STAT_ADR = 0;

    localparam logic [2:0] BUB_STAT  = 3'b000;
    localparam logic [3:0] BUB_ICODE = I_NOP;
    localparam logic       BUB_COND  = 1'b1;
    localparam logic [3:0] BUB_REG   = RNONE;

    // {ZF, SF, OF} out of reset: result looked like zero.
    localparam logic [2:0] CC_RESET = 3'b100;

    typedef enum logic [1:0] {
        S_IDLE,
        S_MUL,
        S_DONE
    } mul_state_t;

    function automatic logic stat_ok(input logic [2:0] s);
        return !(s[STAT_HLT] || s[STAT_INS] || s[STAT_ADR]);
    endfunction

endpackage

// File: rtl/execute_mc_if.sv
// Decode/E-register inputs, hazard controls and E/M-stage outputs of the execute stage.
interface execute_mc_if #(parameter int W = 64);
    logic [3:0]   E_icode;
    logic [3:0]   E_ifun;
    logic [W-1:0] E_valA;
    logic [W-1:0] E_valB;
    logic [W-1:0] E_valC;
    logic [3:0]   E_dstE;
    logic [3:0]   E_dstM;
    logic [2:0]   E_stat;
    logic [2:0]   m_stat;
    logic [2:0]   W_stat;
    logic         M_stall;
    logic         M_bubble;

    logic [W-1:0] e_valE;
    logic [3:0]   e_dstE;
    logic         e_cond;
    logic         e_busy;
    logic [2:0]   cc;

    logic [2:0]   M_stat;
    logic [3:0]   M_icode;
    logic         M_cond;
    logic [W-1:0] M_valE;
    logic [W-1:0] M_valA;
    logic [3:0]   M_dstE;
    logic [3:0]   M_dstM;

    modport master (
        output E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
               E_stat, m_stat, W_stat, M_stall, M_bubble,
        input  e_valE, e_dstE, e_cond, e_busy, cc,
               M_stat, M_icode, M_cond, M_valE, M_valA, M_dstE, M_dstM
    );

    modport slave (
        input  E_icode, E_ifun, E_valA, E_valB, E_valC, E_dstE, E_dstM,
               E_stat, m_stat, W_stat, M_stall, M_bubble,
        output e_valE, e_dstE, e_cond, e_busy, cc,
               M_stat, M_icode, M_cond, M_valE, M_valA, M_dstE, M_dstM
    );
endinterface

// File: rtl/mul_iter.sv
// Signed shift-add multiplier: one partial product per cycle, W cycles per start.
module mul_iter #(
    parameter int W = 64
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           start,
    input  logic [W-1:0]   a,
    input  logic [W-1:0]   b,
    output logic           busy,
    output logic           done,
    output logic [2*W-1:0] prod,
    output logic           ovf
);
    localparam int            CW   = $clog2(W);
    localparam logic [CW-1:0] LAST = CW'(W - 1);

    logic [2*W-1:0] mcand;
    logic [W-1:0]   mplier;
    logic [CW-1:0]  cnt;

    assign done = busy && (cnt == LAST);
    // Product fits in W bits only if the upper half is pure sign extension.
    assign ovf  = (prod[2*W-1:W] != {W{prod[W-1]}});

    // Accumulate; the multiplier sign bit carries negative weight, so the last step subtracts.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            busy   <= 1'b0;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= '0;
            mplier <= '0;
        end else if (start) begin
            busy   <= 1'b1;
            cnt    <= '0;
            prod   <= '0;
            mcand  <= {{W{a[W-1]}}, a};
            mplier <= b;
        end else if (busy) begin
            if (mplier[0]) begin
                prod <= (cnt == LAST) ? prod - mcand : prod + mcand;
            end
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            cnt    <= cnt + 1'b1;
            if (cnt == LAST) begin
                busy <= 1'b0;
            end
        end
    end
endmodule

// File: rtl/execute_mc.sv
// Y86-64 execute stage: ALU, condition codes, iterative mulq and the E->M register.
//  state  | meaning
//  IDLE   | no multiply in flight; single-cycle ops pass straight through
//  MUL    | shift-add steps running; E held via e_busy, M fed bubbles
//  DONE   | product on e_valE; waits here until M captures it
module execute_mc
    import y86_pkg::*;
#(
    parameter int W        = 64,
    parameter bit MUL_EN   = 1'b1,
    parameter int STK_STEP = W / 8
) (
    input logic         clk,
    input logic         rst,
    execute_mc_if.slave bus
);
    mul_state_t     state;
    logic           mul_det, mul_start, mul_busy, mul_done, mul_ovf;
    logic [2*W-1:0] mul_prod;
    logic           unused_prod_hi;

    logic [W-1:0]   alu_r, val_e;
    logic           alu_of, alu_ok, alu_final;
    logic           cc_we, cond, is_cj;
    logic [2:0]     cc_q;
    logic           zf, sf, of_f;

    assign {zf, sf, of_f} = cc_q;
    assign bus.cc         = cc_q;
    assign unused_prod_hi = ^mul_prod[2*W-1:W];

    assign mul_det   = MUL_EN && (bus.E_icode == I_OPQ) && (bus.E_ifun == F_MUL)
                       && stat_ok(bus.E_stat) && !bus.M_bubble;
    assign mul_start = (state == S_IDLE) && mul_det;

    mul_iter #(.W(W)) u_mul (
        .clk   (clk),
        .rst   (rst),
        .start (mul_start),
        .a     (bus.E_valB),
        .b     (bus.E_valA),
        .busy  (mul_busy),
        .done  (mul_done),
        .prod  (mul_prod),
        .ovf   (mul_ovf)
    );

    // ALU result and overflow; mul only counts as final once the FSM sits in DONE.
    always_comb begin
        alu_r     = '0;
        alu_of    = 1'b0;
        alu_ok    = 1'b1;
        alu_final = 1'b1;
        case (bus.E_ifun)
            F_ADD: begin
                alu_r  = bus.E_valB + bus.E_valA;
                alu_of = (bus.E_valA[W-1] == bus.E_valB[W-1]) && (alu_r[W-1] != bus.E_valB[W-1]);
            end
            F_SUB: begin
                alu_r  = bus.E_valB - bus.E_valA;
                alu_of = (bus.E_valA[W-1] != bus.E_valB[W-1]) && (alu_r[W-1] != bus.E_valB[W-1]);
            end
            F_AND: alu_r = bus.E_valB & bus.E_valA;
            F_XOR: alu_r = bus.E_valB ^ bus.E_valA;
            F_MUL: begin
                if (MUL_EN) begin
                    alu_final = (state == S_DONE) && !bus.M_bubble;
                    if (state == S_DONE) begin
                        alu_r  = mul_prod[W-1:0];
                        alu_of = mul_ovf;
                    end
                end else begin
                    alu_ok = 1'b0;
                end
            end
            default: alu_ok = 1'b0;
        endcase
    end

    // Result selection by instruction class.
    always_comb begin
        val_e = '0;
        case (bus.E_icode)
            I_CMOVXX:         val_e = bus.E_valA;
            I_IRMOVQ:         val_e = bus.E_valC;
            I_RMMOVQ,
            I_MRMOVQ:         val_e = bus.E_valB + bus.E_valC;
            I_CALL, I_PUSHQ:  val_e = bus.E_valB - W'(STK_STEP);
            I_RET, I_POPQ:    val_e = bus.E_valB + W'(STK_STEP);
            I_OPQ:            val_e = alu_ok ? alu_r : '0;
            I_HALT, I_NOP:    val_e = '0;
            default:          val_e = '0;
        endcase
    end

    // Branch/cmov condition from the registered flags.
    always_comb begin
        cond = 1'b0;
        case (bus.E_ifun)
            C_ALWAYS: cond = 1'b1;
            C_LE:     cond = (sf ^ of_f) | zf;
            C_L:      cond = sf ^ of_f;
            C_E:      cond = zf;
            C_NE:     cond = !zf;
            C_GE:     cond = !(sf ^ of_f);
            C_G:      cond = !(sf ^ of_f) && !zf;
            default:  cond = 1'b0;
        endcase
    end

    assign is_cj      = (bus.E_icode == I_CMOVXX) || (bus.E_icode == I_JXX);
    assign bus.e_cond = is_cj && cond;
    assign bus.e_dstE = ((bus.E_icode == I_CMOVXX) && !cond) ? RNONE : bus.E_dstE;
    assign bus.e_valE = val_e;
    assign bus.e_busy = mul_start || (state == S_MUL);

    // Flags only move for a final OPq result while no older/current stage has faulted.
    assign cc_we = (bus.E_icode == I_OPQ) && alu_ok && alu_final && stat_ok(bus.E_stat)
                   && stat_ok(bus.m_stat) && stat_ok(bus.W_stat);

    // Condition-code register.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cc_q <= CC_RESET;
        end else if (cc_we) begin
            cc_q <= {alu_r == '0, alu_r[W-1], alu_of};
        end
    end

    // Multiply sequencing; an M bubble flushes whatever is in flight.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= S_IDLE;
        end else begin
            case (state)
                S_IDLE: if (mul_det) state <= S_MUL;
                S_MUL: begin
                    if (bus.M_bubble || !mul_busy) state <= S_IDLE;
                    else if (mul_done)             state <= S_DONE;
                end
                S_DONE: if (bus.M_bubble || !bus.M_stall) state <= S_IDLE;
                default: state <= S_IDLE;
            endcase
        end
    end

    // E->M pipeline register: bubble, then hold, then busy-bubble, then load.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bus.M_stat  <= BUB_STAT;
            bus.M_icode <= BUB_ICODE;
            bus.M_cond  <= BUB_COND;
            bus.M_valE  <= '0;
            bus.M_valA  <= '0;
            bus.M_dstE  <= BUB_REG;
            bus.M_dstM  <= BUB_REG;
        end else if (bus.M_bubble || (!bus.M_stall && bus.e_busy)) begin
            bus.M_stat  <= BUB_STAT;
            bus.M_icode <= BUB_ICODE;
            bus.M_cond  <= BUB_COND;
            bus.M_valE  <= '0;
            bus.M_valA  <= '0;
            bus.M_dstE  <= BUB_REG;
            bus.M_dstM  <= BUB_REG;
        end else if (!bus.M_stall) begin
            bus.M_stat  <= bus.E_stat;
            bus.M_icode <= bus.E_icode;
            bus.M_cond  <= is_cj ? cond : 1'b1;
            bus.M_valE  <= val_e;
            bus.M_valA  <= bus.E_valA;
            bus.M_dstE  <= bus.e_dstE;
            bus.M_dstM  <= bus.E_dstM;
        end
    end
endmodule

// File: tb/tb_execute_mc.sv
// Directed-vector bench for the execute stage with iterative mulq.
module tb_execute_mc;
    import y86_pkg::*;

    localparam int W = 64;

    logic clk = 1'b0;
    logic rst;
    int   vectors = 0;
    int   miscompares = 0;

    execute_mc_if #(.W(W)) bus();

    execute_mc #(.W(W), .MUL_EN(1'b1), .STK_STEP(8)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [3:0] icode, input logic [3:0] ifun,
                         input logic [W-1:0] a, input logic [W-1:0] b,
                         input logic [W-1:0] c, input logic [3:0] dste);
        bus.E_icode = icode;
        bus.E_ifun  = ifun;
        bus.E_valA  = a;
        bus.E_valB  = b;
        bus.E_valC  = c;
        bus.E_dstE  = dste;
        bus.E_dstM  = RNONE;
        #1;
    endtask

    // Runs until e_busy drops (bounded); reports busy cycles and bubbles seen in M.
    task automatic run_mul(output int n, output int bub);
        n = 0;
        bub = 0;
        while (bus.e_busy === 1'b1 && n < 200) begin
            tick();
            n++;
            if (bus.M_icode === I_NOP && bus.M_dstE === RNONE && bus.M_valE === '0) bub++;
        end
    endtask

    task automatic test_reset();
        rst = 1'b1;
        drive(I_NOP, 4'h0, '0, '0, '0, RNONE);
        tick();
        tick();
        vectors++; if (bus.cc !== 3'b100) begin miscompares++; $display("FAIL reset_cc got %b exp 100", bus.cc); end
        vectors++; if (bus.M_icode !== 4'h1 || bus.M_dstE !== 4'hF || bus.M_dstM !== 4'hF || bus.M_cond !== 1'b1)
            begin miscompares++; $display("FAIL reset_m got icode %h dstE %h dstM %h cond %b exp 1 f f 1", bus.M_icode, bus.M_dstE, bus.M_dstM, bus.M_cond); end
        vectors++; if (bus.M_valE !== '0 || bus.e_busy !== 1'b0)
            begin miscompares++; $display("FAIL reset_misc got valE %h busy %b exp 0 0", bus.M_valE, bus.e_busy); end
        rst = 1'b0;
    endtask

    task automatic test_addq();
        drive(I_OPQ, F_ADD, 64'd1, 64'h7FFF_FFFF_FFFF_FFFF, '0, 4'h2);
        vectors++; if (bus.e_valE !== 64'h8000_0000_0000_0000) begin miscompares++; $display("FAIL add_valE got %h exp 8000000000000000", bus.e_valE); end
        tick();
        vectors++; if (bus.cc !== 3'b011) begin miscompares++; $display("FAIL add_cc got %b exp 011", bus.cc); end
        vectors++; if (bus.M_valE !== 64'h8000_0000_0000_0000 || bus.M_icode !== I_OPQ || bus.M_dstE !== 4'h2)
            begin miscompares++; $display("FAIL add_m got valE %h icode %h dstE %h", bus.M_valE, bus.M_icode, bus.M_dstE); end
    endtask

    task automatic test_sub_cond();
        drive(I_OPQ, F_SUB, 64'd5, 64'd5, '0, 4'h2);
        vectors++; if (bus.e_valE !== '0) begin miscompares++; $display("FAIL sub_valE got %h exp 0", bus.e_valE); end
        tick();
        vectors++; if (bus.cc !== 3'b100) begin miscompares++; $display("FAIL sub_cc got %b exp 100", bus.cc); end
        drive(I_JXX, C_LE, '0, '0, 64'h40, RNONE);
        vectors++; if (bus.e_cond !== 1'b1) begin miscompares++; $display("FAIL jle_cond got %b exp 1", bus.e_cond); end
        drive(I_JXX, C_G, '0, '0, 64'h40, RNONE);
        vectors++; if (bus.e_cond !== 1'b0) begin miscompares++; $display("FAIL jg_cond got %b exp 0", bus.e_cond); end
        tick();
        vectors++; if (bus.M_cond !== 1'b0) begin miscompares++; $display("FAIL jg_mcond got %b exp 0", bus.M_cond); end
        drive(I_JXX, 4'h7, '0, '0, 64'h40, RNONE);
        vectors++; if (bus.e_cond !== 1'b0) begin miscompares++; $display("FAIL jbad_cond got %b exp 0", bus.e_cond); end
        drive(I_IRMOVQ, C_ALWAYS, '0, '0, 64'h1, 4'h1);
        vectors++; if (bus.e_cond !== 1'b0) begin miscompares++; $display("FAIL irmov_cond got %b exp 0", bus.e_cond); end
    endtask

    task automatic test_cmov();
        drive(I_CMOVXX, C_NE, 64'h55, '0, '0, 4'h3);
        vectors++; if (bus.e_dstE !== 4'hF || bus.e_valE !== 64'h55)
            begin miscompares++; $display("FAIL cmovne_comb got dstE %h valE %h exp f 55", bus.e_dstE, bus.e_valE); end
        tick();
        vectors++; if (bus.M_cond !== 1'b0 || bus.M_dstE !== 4'hF)
            begin miscompares++; $display("FAIL cmovne_m got cond %b dstE %h exp 0 f", bus.M_cond, bus.M_dstE); end
        drive(I_CMOVXX, C_ALWAYS, 64'h55, '0, '0, 4'h3);
        vectors++; if (bus.e_dstE !== 4'h3) begin miscompares++; $display("FAIL rrmov_dstE got %h exp 3", bus.e_dstE); end
        tick();
        vectors++; if (bus.M_cond !== 1'b1 || bus.M_dstE !== 4'h3)
            begin miscompares++; $display("FAIL rrmov_m got cond %b dstE %h exp 1 3", bus.M_cond, bus.M_dstE); end
    endtask

    task automatic test_valE();
        logic [3:0]   ic [10];
        logic [3:0]   fn [10];
        logic [W-1:0] vb [10];
        logic [W-1:0] vc [10];
        logic [W-1:0] ex [10];
        ic = '{I_IRMOVQ, I_RMMOVQ, I_MRMOVQ, I_CALL, I_PUSHQ, I_RET, I_POPQ, I_NOP, I_HALT, I_OPQ};
        fn = '{4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h0, 4'h7};
        vb = '{64'h0, 64'h100, 64'h200, 64'h100, 64'h100, 64'h100, 64'h100, 64'h9, 64'h9, 64'h9};
        vc = '{64'h123, 64'h10, 64'h8, 64'h0, 64'h0, 64'h0, 64'h0, 64'h9, 64'h9, 64'h9};
        ex = '{64'h123, 64'h110, 64'h208, 64'hF8, 64'hF8, 64'h108, 64'h108, 64'h0, 64'h0, 64'h0};
        for (int i = 0; i < 10; i++) begin
            drive(ic[i], fn[i], 64'h7, vb[i], vc[i], 4'h4);
            vectors++; if (bus.e_valE !== ex[i])
                begin miscompares++; $display("FAIL valE_%0d got %h exp %h", i, bus.e_valE, ex[i]); end
        end
        tick();
        vectors++; if (bus.cc !== 3'b100) begin miscompares++; $display("FAIL badop_cc got %b exp 100", bus.cc); end
    endtask

    task automatic test_stat_gate();
        bus.m_stat = 3'b100;
        drive(I_OPQ, F_ADD, 64'd1, 64'd2, '0, 4'h2);
        vectors++; if (bus.e_valE !== 64'd3) begin miscompares++; $display("FAIL gate_valE got %h exp 3", bus.e_valE); end
        tick();
        vectors++; if (bus.cc !== 3'b100) begin miscompares++; $display("FAIL gate_mstat_cc got %b exp 100", bus.cc); end
        bus.m_stat = 3'b000;
        bus.W_stat = 3'b001;
        tick();
        vectors++; if (bus.cc !== 3'b100) begin miscompares++; $display("FAIL gate_wstat_cc got %b exp 100", bus.cc); end
        bus.W_stat = 3'b000;
        tick();
        vectors++; if (bus.cc !== 3'b000) begin miscompares++; $display("FAIL gate_open_cc got %b exp 000", bus.cc); end
    endtask

    task automatic test_mul();
        int n, bub;
        drive(I_OPQ, F_MUL, 64'hFFFF_FFFF_FFFF_FFFD, 64'd7, '0, 4'h5);
        vectors++; if (bus.e_busy !== 1'b1) begin miscompares++; $display("FAIL mul_start_busy got %b exp 1", bus.e_busy); end
        run_mul(n, bub);
        vectors++; if (n != 65 || bub != 65) begin miscompares++; $display("FAIL mul_busy_len got %0d/%0d bubbles exp 65/65", n, bub); end
        vectors++; if (bus.e_valE !== 64'hFFFF_FFFF_FFFF_FFEB || bus.cc !== 3'b000)
            begin miscompares++; $display("FAIL mul_done got valE %h cc %b exp ffffffffffffffeb 000", bus.e_valE, bus.cc); end
        tick();
        vectors++; if (bus.M_valE !== 64'hFFFF_FFFF_FFFF_FFEB || bus.M_icode !== I_OPQ || bus.M_dstE !== 4'h5)
            begin miscompares++; $display("FAIL mul_m got valE %h icode %h dstE %h", bus.M_valE, bus.M_icode, bus.M_dstE); end
        vectors++; if (bus.cc !== 3'b010) begin miscompares++; $display("FAIL mul_cc got %b exp 010", bus.cc); end
        drive(I_OPQ, F_MUL, 64'h100_0000_0000, 64'h100_0000_0000, '0, 4'h5);
        run_mul(n, bub);
        vectors++; if (n != 65 || bus.e_valE !== '0)
            begin miscompares++; $display("FAIL mulbig_done got cycles %0d valE %h exp 65 0", n, bus.e_valE); end
        tick();
        drive(I_NOP, 4'h0, '0, '0, '0, RNONE);
        vectors++; if (bus.cc !== 3'b101 || bus.e_busy !== 1'b0)
            begin miscompares++; $display("FAIL mulbig_cc got %b busy %b exp 101 0", bus.cc, bus.e_busy); end
    endtask

    task automatic test_abort();
        drive(I_OPQ, F_MUL, 64'd6, 64'd7, '0, 4'h5);
        repeat (5) tick();
        bus.M_bubble = 1'b1;
        #1;
        vectors++; if (bus.e_busy !== 1'b1) begin miscompares++; $display("FAIL abort_pre_busy got %b exp 1", bus.e_busy); end
        tick();
        bus.M_bubble = 1'b0;
        drive(I_NOP, 4'h0, '0, '0, '0, RNONE);
        vectors++; if (bus.e_busy !== 1'b0 || bus.M_icode !== I_NOP)
            begin miscompares++; $display("FAIL abort_state got busy %b icode %h exp 0 1", bus.e_busy, bus.M_icode); end
        tick();
        vectors++; if (bus.cc !== 3'b101) begin miscompares++; $display("FAIL abort_cc got %b exp 101", bus.cc); end
    endtask

    task automatic test_stall_and_rst();
        int n, bub;
        drive(I_OPQ, F_MUL, 64'd6, 64'd7, 64'd0, 4'h5);
        run_mul(n, bub);
        vectors++; if (n != 65) begin miscompares++; $display("FAIL stall_mul_len got %0d exp 65", n); end
        bus.M_stall = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            vectors++; if (bus.e_valE !== 64'd42 || bus.e_busy !== 1'b0 || bus.M_icode !== I_NOP)
                begin miscompares++; $display("FAIL stall_hold_%0d got valE %h busy %b Micode %h exp 2a 0 1", i, bus.e_valE, bus.e_busy, bus.M_icode); end
        end
        bus.M_stall = 1'b0;
        tick();
        vectors++; if (bus.M_valE !== 64'd42 || bus.M_icode !== I_OPQ || bus.cc !== 3'b000)
            begin miscompares++; $display("FAIL stall_release got valE %h icode %h cc %b exp 2a 6 000", bus.M_valE, bus.M_icode, bus.cc); end
        vectors++; if (bus.e_busy !== 1'b1) begin miscompares++; $display("FAIL stall_restart got busy %b exp 1", bus.e_busy); end
        repeat (10) tick();
        rst = 1'b1;
        drive(I_NOP, 4'h0, '0, '0, '0, RNONE);
        vectors++; if (bus.e_busy !== 1'b0 || bus.M_icode !== I_NOP || bus.M_valE !== '0 || bus.cc !== 3'b100)
            begin miscompares++; $display("FAIL rst_mid got busy %b icode %h valE %h cc %b exp 0 1 0 100", bus.e_busy, bus.M_icode, bus.M_valE, bus.cc); end
        tick();
        rst = 1'b0;
        tick();
        vectors++; if (bus.e_busy !== 1'b0 || bus.cc !== 3'b100)
            begin miscompares++; $display("FAIL rst_after got busy %b cc %b exp 0 100", bus.e_busy, bus.cc); end
    endtask

    initial begin
        bus.E_stat   = 3'b000;
        bus.m_stat   = 3'b000;
        bus.W_stat   = 3'b000;
        bus.M_stall  = 1'b0;
        bus.M_bubble = 1'b0;
        test_reset();
        test_addq();
        test_sub_cond();
        test_cmov();
        test_valE();
        test_stat_gate();
        test_mul();
        test_abort();
        test_stall_and_rst();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog timeout after %0d vectors", vectors);
        $fatal(1, "watchdog");
    end
endmodule

// File: doc/execute_mc.md
Name: execute_mc

Overview:
- Parametrised Y86-64-style execute stage with a clocked condition-code (CC) register and the E→M pipeline register.
- Adds over the previous execute stage: data width parameter; gated CC updates; M-register stall and bubble; a multi-cycle iterative `mulq` (OPq ifun 4) that holds the E stage through a busy handshake.
- Sits between decode (E register) and memory (M register); `e_busy` feeds the hazard unit.

Parameters:
- W, 64, datapath width in bits, ≥8, multiple of 8
- MUL_EN, 1, 1 = `mulq` supported; 0 = OPq ifun 4 treated as invalid
- STK_STEP, W/8, byte decrement/increment applied to %rsp by call/push/ret/pop

Ports:
- clk  in  1  clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- E_icode, E_ifun  in  4 each  instruction in E
- E_valA, E_valB, E_valC  in  W each  signed operands
- E_dstE, E_dstM  in  4 each  destination registers; 4'hF = none
- E_stat, m_stat, W_stat  in  3 each  {hlt, in_inst, in_mem} status of E, memory-stage, W
- M_stall  in  1  hold M register
- M_bubble  in  1  load nop into M register
- e_valE  out  W  combinational result
- e_dstE  out  4  E_dstE, or 4'hF for a not-taken cmov
- e_cond  out  1  branch/cmov condition
- e_busy  out  1  multiply in progress; hazard unit must stall F/D/E
- cc  out  3  {ZF, SF, OF}
- M_stat, M_icode, M_cond, M_valE, M_valA, M_dstE, M_dstM  out  3/4/1/W/W/4/4  M register

Behaviour:
- Reset, asynchronous: state IDLE; counter 0; cc = 3'b100; M register = bubble values (stat 0, icode 4'h1, cond 1, valE 0, valA 0, dstE 4'hF, dstM 4'hF).
- e_valE by icode:
  - cmov: valA
  - irmov: valC
  - rmmov/mrmov: valB + valC
  - call/push: valB − STK_STEP
  - ret/pop: valB + STK_STEP
  - OPq: ALU result
  - all others: 0
- OPq ifun, with result computed as valB op valA:
  - 0 add; 1 sub (valB − valA); 2 and; 3 xor
  - 4 mul: low W bits of the signed product
  - any other ifun, or 4 with MUL_EN=0: e_valE = 0, CC not updated
- Flags: ZF = (result == 0); SF = result[W−1].
  - add: OF = sA==sB && sR!=sB
  - sub: OF = sA!=sB && sR!=sB
  - and/xor: OF = 0
  - mul: OF = 1 if the 2W-bit product does not equal sign-extension of its low W bits
- CC update: at posedge when icode==OPq, ifun valid, m_stat==0, W_stat==0, E_stat==0, and the result is final (single-cycle op, or mul in DONE). No update otherwise.
- Conditions on ifun 0..6 (always, le, l, e, ne, ge, g), evaluated on the registered cc. ifun > 6 → e_cond = 0. e_cond = 0 for non-cmov/jxx icodes.
- Multiply FSM, states IDLE, MUL, DONE:
  - IDLE → MUL: when icode==OPq, ifun==4, MUL_EN, E_stat==0, M_bubble==0. Operands latched; counter = 0.
  - MUL: one shift-add step per cycle; → DONE when counter == W−1. Total mul residency in E = W+2 cycles.
  - DONE: product on e_valE; CC updated (if gated); M loads the result unless M_stall. → IDLE at the edge where M captures. Stays DONE while M_stall=1.
  - e_busy = (IDLE && mul detected) || MUL. e_busy = 0 in DONE.
  - M_bubble in MUL or DONE: abort to IDLE, no CC update.
  - rst mid-multiply: immediate IDLE.
- M register priority, highest first:
  - M_bubble → bubble values
  - M_stall → hold
  - e_busy → bubble values
  - otherwise → load {E_stat, E_icode, e_cond, e_valE, E_valA, e_dstE, E_dstM}
- M_cond = e_cond for cmov/jxx; 1 for all other icodes.

Decomposition:
- Package `y86_pkg`:
  - icode constants (HALT…POPQ)
  - ifun constants for OPq (ADD, SUB, AND, XOR, MUL) and conditions
  - RNONE = 4'hF
  - stat bit positions
  - bubble constant values
- Sub-module `mul_iter`:
  - W-parametrised signed iterative multiplier
  - ports: start, a, b, busy, done, prod[2W−1:0], ovf
  - controlled by this block's FSM

Test Plan:
- Reset, then W=64 addq valA=1, valB=0x7FFF_FFFF_FFFF_FFFF → e_valE=0x8000_0000_0000_0000; next cycle cc=3'b011; M_valE matches.
- subq valA=5, valB=5 → e_valE=0; cc=3'b100. Then jle (ifun 1) → e_cond=1; jg (ifun 6) → e_cond=0.
- cmovne (ifun 4) with ZF=1, E_dstE=3 → e_dstE=4'hF, M_cond=0. Then rrmovq → e_dstE=3.
- mulq valA=−3, valB=7 → e_busy high for 65 cycles, M receives 65 bubbles, then M_valE=−21 and cc=3'b010. Repeat with 2^40 × 2^40 → OF=1.
- m_stat=3'b100 during addq → cc unchanged. Assert M_stall in DONE for 3 cycles → e_valE held, single M load after release. Assert rst at mul cycle 10 → e_busy=0, M bubble, cc=3'b100.
